led_pattern_gen: RTL and testbench

//  Multi-channel LED pattern generator. Replaces fixed counter-bit-to-LED wiring in board tops.

---
 rtl/led_pattern_gen_pkg.sv | 22 ++
 rtl/led_pattern_gen_sync2.sv | 26 ++
 rtl/led_pattern_gen.sv | 164 ++++++++++++++++
 tb/tb_led_pattern_gen.sv | 229 ++++++++++++++++++++++
 4 files changed

// File: rtl/led_pattern_gen_pkg.sv
// Shared encodings for the LED pattern generator: operating modes and the
// direction/ramp states of the chase and breathing pattern FSMs.
package led_pattern_pkg;

    typedef enum logic [1:0] {
        MODE_COUNT   = 2'd0,
        MODE_CHASE   = 2'd1,
        MODE_BREATHE = 2'd2,
        MODE_EXT     = 2'd3
    } mode_e;

    typedef enum logic {
        DIR_UP   = 1'b0,
        DIR_DOWN = 1'b1
    } dir_e;

    typedef enum logic {
        RAMP_RISE = 1'b0,
        RAMP_FALL = 1'b1
    } ramp_e;

endpackage

// File: rtl/led_pattern_gen_sync2.sv
// Two-flop synchroniser for asynchronous PMOD inputs; both stages clear on reset.
module sync2 #(
    parameter int W = 1
) (
    input  logic         clk,
    input  logic         reset_n,
    input  logic [W-1:0] i_d,
    output logic [W-1:0] o_q
);

    logic [W-1:0] r_meta;
    logic [W-1:0] r_sync;

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            r_meta <= '0;
            r_sync <= '0;
        end else begin
            r_meta <= i_d;
            r_sync <= r_meta;
        end
    end

    assign o_q = r_sync;

endmodule

// File: rtl/led_pattern_gen.sv
// Multi-channel LED pattern generator: counter taps, bounce chase, breathing PWM
// or external pass-through, selected by a synchronised mode input.
module led_pattern_gen #(
    parameter int NUM_LEDS     = 5,
    parameter int CNT_W        = 32,
    parameter int TAP_LSB      = 21,
    parameter int STEP_LOG2    = 22,
    parameter int BREATHE_LOG2 = 14,
    parameter int PWM_W        = 8
) (
    input  logic                clk,
    input  logic                reset_n,
    input  logic [1:0]          mode,
    input  logic                hold,
    input  logic [NUM_LEDS-1:0] ext_in,
    output logic [NUM_LEDS-1:0] led,
    output logic                step
);
    import led_pattern_pkg::*;

    localparam int POS_W = (NUM_LEDS > 1) ? $clog2(NUM_LEDS) : 1;
    localparam logic [POS_W-1:0] POS_MAX = POS_W'(NUM_LEDS - 1);

    logic [1:0]          w_modeS;
    logic                w_holdS;
    logic [NUM_LEDS-1:0] w_extS;

    sync2 #(.W(2)) u_syncMode (
        .clk     (clk),
        .reset_n (reset_n),
        .i_d     (mode),
        .o_q     (w_modeS)
    );

    sync2 #(.W(1)) u_syncHold (
        .clk     (clk),
        .reset_n (reset_n),
        .i_d     (hold),
        .o_q     (w_holdS)
    );

    sync2 #(.W(NUM_LEDS)) u_syncExt (
        .clk     (clk),
        .reset_n (reset_n),
        .i_d     (ext_in),
        .o_q     (w_extS)
    );

    logic [CNT_W-1:0]    r_cnt;
    mode_e               r_modeQ;
    logic [POS_W-1:0]    r_pos;
    dir_e                r_dir;
    logic [PWM_W-1:0]    r_duty;
    ramp_e               r_ramp;
    logic [NUM_LEDS-1:0] r_led;
    logic                r_step;

    mode_e               w_modeNext;
    logic [POS_W-1:0]    w_posNext;
    dir_e                w_dirNext;
    logic [PWM_W-1:0]    w_dutyNext;
    ramp_e               w_rampNext;
    logic [NUM_LEDS-1:0] w_ledNext;
    logic                w_stepTick;
    logic                w_brTick;
    logic                w_modeChange;

    assign w_stepTick   = ~w_holdS & (&r_cnt[STEP_LOG2-1:0]);
    assign w_brTick     = ~w_holdS & (&r_cnt[BREATHE_LOG2-1:0]);
    assign w_modeChange = (mode_e'(w_modeS) != r_modeQ);

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            r_cnt   <= '0;
            r_modeQ <= MODE_COUNT;
            r_pos   <= '0;
            r_dir   <= DIR_UP;
            r_duty  <= '0;
            r_ramp  <= RAMP_RISE;
            r_led   <= '0;
            r_step  <= 1'b0;
        end else begin
            r_cnt   <= w_holdS ? r_cnt : r_cnt + 1'b1;
            r_modeQ <= w_modeNext;
            r_pos   <= w_posNext;
            r_dir   <= w_dirNext;
            r_duty  <= w_dutyNext;
            r_ramp  <= w_rampNext;
            r_led   <= w_ledNext;
            r_step  <= w_stepTick;
        end
    end

    // A mode change restarts both pattern FSMs and swallows any coincident tick.
    always_comb begin
        w_modeNext = r_modeQ;
        w_posNext  = r_pos;
        w_dirNext  = r_dir;
        w_dutyNext = r_duty;
        w_rampNext = r_ramp;
        if (w_modeChange) begin
            w_modeNext = mode_e'(w_modeS);
            w_posNext  = '0;
            w_dirNext  = DIR_UP;
            w_dutyNext = '0;
            w_rampNext = RAMP_RISE;
        end else begin
            if (r_modeQ == MODE_CHASE && w_stepTick) begin
                case (r_dir)
                    DIR_UP: begin
                        if (r_pos == POS_MAX) begin
                            w_dirNext = DIR_DOWN;
                            w_posNext = POS_MAX - 1'b1;
                        end else begin
                            w_posNext = r_pos + 1'b1;
                        end
                    end
                    default: begin
                        if (r_pos == '0) begin
                            w_dirNext = DIR_UP;
                            w_posNext = POS_W'(1);
                        end else begin
                            w_posNext = r_pos - 1'b1;
                        end
                    end
                endcase
            end
            if (r_modeQ == MODE_BREATHE && w_brTick) begin
                case (r_ramp)
                    RAMP_RISE: begin
                        if (&r_duty) begin
                            w_rampNext = RAMP_FALL;
                            w_dutyNext = r_duty - 1'b1;
                        end else begin
                            w_dutyNext = r_duty + 1'b1;
                        end
                    end
                    default: begin
                        if (r_duty == '0) begin
                            w_rampNext = RAMP_RISE;
                            w_dutyNext = r_duty + 1'b1;
                        end else begin
                            w_dutyNext = r_duty - 1'b1;
                        end
                    end
                endcase
            end
        end
    end

    always_comb begin
        w_ledNext = '0;
        case (r_modeQ)
            MODE_COUNT:   w_ledNext = r_cnt[TAP_LSB +: NUM_LEDS];
            MODE_CHASE:   w_ledNext = NUM_LEDS'(1) << r_pos;
            MODE_BREATHE: w_ledNext = {NUM_LEDS{r_cnt[PWM_W-1:0] < r_duty}};
            default:      w_ledNext = w_extS;
        endcase
    end

    assign led  = r_led;
    assign step = r_step;

endmodule

// File: tb/tb_led_pattern_gen.sv
// Self-checking bench: a behavioural reference model queues expected led/step
// values at each clock edge; a negedge checker pops and compares them.
module tb_led_pattern_gen;

    logic       clk = 1'b0;
    logic       reset_n;
    logic [1:0] mode;
    logic       hold;
    logic [3:0] ext_in;
    logic [3:0] led;
    logic       step;

    int total = 0;
    int bad   = 0;

    led_pattern_gen #(
        .NUM_LEDS     (4),
        .CNT_W        (8),
        .TAP_LSB      (2),
        .STEP_LOG2    (3),
        .BREATHE_LOG2 (1),
        .PWM_W        (3)
    ) dut (
        .clk     (clk),
        .reset_n (reset_n),
        .mode    (mode),
        .hold    (hold),
        .ext_in  (ext_in),
        .led     (led),
        .step    (step)
    );

    always #5 clk = ~clk;

    task automatic checkOutput(input string tag, input logic [7:0] act, input logic [7:0] exp);
        total++;
        if (act !== exp) begin
            bad++;
            $display("[TB] FAIL %s: got %0h expected %0h at %0t", tag, act, exp, $time);
        end
    endtask

    task automatic applyStimulus(input logic [1:0] m, input logic h, input logic [3:0] e);
        mode   = m;
        hold   = h;
        ext_in = e;
    endtask

    task automatic waitClocks(input int n);
        repeat (n) @(negedge clk);
    endtask

    logic [7:0] m_cnt;
    logic [1:0] m_modeQ, m_modeA, m_modeB;
    logic       m_holdA, m_holdB;
    logic [3:0] m_extA, m_extB;
    int         m_pos, m_duty;
    logic       m_up, m_rise;
    logic       m_tickS, m_tickB;
    logic [3:0] m_led;
    logic [4:0] sbQ[$];
    logic [4:0] sbE;

    // Reference model written straight from the behavioural description.
    always @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            m_cnt = 0; m_modeQ = 0; m_modeA = 0; m_modeB = 0;
            m_holdA = 0; m_holdB = 0; m_extA = 0; m_extB = 0;
            m_pos = 0; m_duty = 0; m_up = 1; m_rise = 1;
            sbQ.delete();
        end else begin
            m_tickS = !m_holdB && (m_cnt[2:0] == 3'b111);
            m_tickB = !m_holdB && m_cnt[0];
            case (m_modeQ)
                2'd0:    m_led = m_cnt[5:2];
                2'd1:    m_led = 4'b0001 << m_pos;
                2'd2:    m_led = (int'(m_cnt[2:0]) < m_duty) ? 4'hF : 4'h0;
                default: m_led = m_extB;
            endcase
            if (m_modeB != m_modeQ) begin
                m_modeQ = m_modeB; m_pos = 0; m_up = 1; m_duty = 0; m_rise = 1;
            end else begin
                if (m_tickS) begin
                    if (m_up) begin
                        if (m_pos == 3) begin m_up = 0; m_pos = 2; end else m_pos++;
                    end else begin
                        if (m_pos == 0) begin m_up = 1; m_pos = 1; end else m_pos--;
                    end
                end
                if (m_tickB) begin
                    if (m_rise) begin
                        if (m_duty == 7) begin m_rise = 0; m_duty = 6; end else m_duty++;
                    end else begin
                        if (m_duty == 0) begin m_rise = 1; m_duty = 1; end else m_duty--;
                    end
                end
            end
            if (!m_holdB) m_cnt = m_cnt + 8'd1;
            m_modeB = m_modeA; m_modeA = mode;
            m_holdB = m_holdA; m_holdA = hold;
            m_extB  = m_extA;  m_extA  = ext_in;
            sbQ.push_back({m_led, m_tickS});
        end
    end

    always @(negedge clk) begin
        if (!reset_n) begin
            checkOutput("rstLed", {4'b0, led}, 8'h00);
            checkOutput("rstStep", {7'b0, step}, 8'h00);
        end else if (sbQ.size() > 0) begin
            sbE = sbQ.pop_front();
            checkOutput("led", {4'b0, led}, {4'b0, sbE[4:1]});
            checkOutput("step", {7'b0, step}, {7'b0, sbE[0]});
        end
    end

    logic [3:0] chaseExp[8] = '{4'h1, 4'h2, 4'h4, 4'h8, 4'h4, 4'h2, 4'h1, 4'h2};
    logic [3:0] got[8];
    logic [3:0] prevLed;
    int         nGot;
    logic       ok;

    initial begin
        applyStimulus(2'd0, 1'b0, 4'h0);
        reset_n = 1'b1;
        #1 reset_n = 1'b0;
        waitClocks(5);
        #2 reset_n = 1'b1;

        // COUNT: look for the tap wrap 1111 -> 0000
        ok = 0;
        prevLed = led;
        for (int i = 0; i < 300; i++) begin
            @(negedge clk);
            if (prevLed == 4'hF && led == 4'h0) begin ok = 1; break; end
            prevLed = led;
        end
        checkOutput("cntWrap", {7'b0, ok}, 8'h01);

        // CHASE: start at 0001 and bounce
        applyStimulus(2'd1, 1'b0, 4'h0);
        waitClocks(4);
        checkOutput("chaseStart", {4'b0, led}, 8'h01);
        for (int i = 0; i < 8; i++) got[i] = 4'h0;
        got[0] = led;
        nGot = 1;
        for (int i = 0; i < 150 && nGot < 8; i++) begin
            @(negedge clk);
            if (led != got[nGot-1]) begin got[nGot] = led; nGot++; end
        end
        for (int i = 0; i < 8; i++)
            checkOutput($sformatf("chaseSeq%0d", i), {4'b0, got[i]}, {4'b0, chaseExp[i]});

        // Hold at 0100 while moving down
        ok = 0;
        for (int i = 0; i < 100; i++) begin
            @(negedge clk);
            if (m_pos == 2 && !m_up && m_cnt[2:0] == 3'd0) begin ok = 1; break; end
        end
        checkOutput("waitDown", {7'b0, ok}, 8'h01);
        applyStimulus(2'd1, 1'b1, 4'h0);
        waitClocks(4);
        for (int i = 0; i < 36; i++) begin
            @(negedge clk);
            checkOutput("holdLed", {4'b0, led}, 8'h04);
            checkOutput("holdStep", {7'b0, step}, 8'h00);
        end
        applyStimulus(2'd1, 1'b0, 4'h0);
        ok = 0;
        for (int i = 0; i < 60; i++) begin
            @(negedge clk);
            if (led != 4'h4) begin ok = 1; break; end
        end
        checkOutput("resumeDown", {3'b0, ok, led}, 8'h12);

        // EXT from pos 3, then back to CHASE on a step-tick clock
        ok = 0;
        for (int i = 0; i < 100; i++) begin
            @(negedge clk);
            if (m_pos == 3) begin ok = 1; break; end
        end
        checkOutput("waitPos3", {7'b0, ok}, 8'h01);
        applyStimulus(2'd3, 1'b0, 4'b1010);
        waitClocks(4);
        checkOutput("extLed", {4'b0, led}, 8'h0A);
        ok = 0;
        for (int i = 0; i < 20; i++) begin
            @(negedge clk);
            if (m_cnt[2:0] == 3'd5) begin ok = 1; break; end
        end
        checkOutput("waitAlign", {7'b0, ok}, 8'h01);
        applyStimulus(2'd1, 1'b0, 4'b1010);
        waitClocks(4);
        checkOutput("chaseRestart", {4'b0, led}, 8'h01);
        waitClocks(7);
        checkOutput("tickIgnored", {4'b0, led}, 8'h01);
        waitClocks(1);
        checkOutput("restartUp", {4'b0, led}, 8'h02);

        // BREATHE, then async reset at duty 5
        applyStimulus(2'd2, 1'b0, 4'h0);
        waitClocks(60);
        ok = 0;
        for (int i = 0; i < 200; i++) begin
            @(negedge clk);
            if (m_modeQ == 2'd2 && m_duty == 5) begin ok = 1; break; end
        end
        checkOutput("waitDuty5", {7'b0, ok}, 8'h01);
        #2 reset_n = 1'b0;
        #1;
        checkOutput("arstLed", {4'b0, led}, 8'h00);
        checkOutput("arstStep", {7'b0, step}, 8'h00);
        waitClocks(2);
        #2 reset_n = 1'b1;
        ok = 0;
        for (int i = 0; i < 10; i++) begin
            @(negedge clk);
            if (m_modeQ == 2'd2) begin ok = 1; break; end
        end
        checkOutput("waitBreathe", {7'b0, ok}, 8'h01);
        @(negedge clk);
        checkOutput("dutyRestart", {4'b0, led}, 8'h00);
        waitClocks(40);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
